regif_ctrl: RTL and testbench
=============================

REGIF_CTRL -- requirements
Module: regif_ctrl

Interface
REQ-001 Parameter ADDR_W, 22, HZZ bus word-address width.
REQ-002 Parameter DATA_W, 32, HZZ bus data width.
REQ-003 Parameter N_UNIT, 7, subunit count; unit index 0..6 = mov_ddr2gb, mov_gb2lb, comp_conv, comp_fc, comp_ape, comp_reshape, lpe.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 regif_addr  input  ADDR_W  register word address.
REQ-007 regif_wdata  input  DATA_W  write data.
REQ-008 regif_wen  input  1  write strobe, one access per high cycle.
REQ-009 regif_ren  input  1  read strobe, one access per high cycle.
REQ-010 regif_rdata  output  DATA_W  read data.
REQ-011 regif_rvalid  output  1  read-data-valid pulse.
REQ-012 start_mov_ddr2gb, start_mov_gb2lb, start_comp_conv, start_comp_fc, start_comp_ape, start_comp_reshape, start_lpe  output  1 each  unit start pulses.
REQ-013 complete_<same seven units>  input  1 each  unit completion pulses.
REQ-014 cfg_reg  output  8*DATA_W  CFG0..CFG7 concatenated, CFG0 in LSBs.

Function
REQ-015 Map (word addr): 0x000 CTRL (W, bit i starts unit i, reads 0); 0x001 STATUS (R: [6:0] busy, [14:8] done, [22:16] err); 0x002 CLR (W1C: bits [14:8] clear done, [22:16] clear err); 0x003 VERSION (R, 0x2CDA0001); 0x004 PERF (R, cycles with any busy; write any value clears); 0x010..0x017 CFG0..7 (RW).
REQ-016 Write at cycle N visible in registers/outputs at N+1; writes to read-only or unmapped addresses ignored.
REQ-017 Read: ren sampled at N -> regif_rdata valid and regif_rvalid=1 at N+1 for exactly one cycle; rdata holds last value otherwise.
REQ-018 Unmapped read returns 0xDEADBEEF with rvalid still asserted.
REQ-019 wen and ren same cycle: both performed; read returns pre-write value.
REQ-020 CTRL bit i=1 with unit i idle: start_i=1 at N+1 for exactly one cycle, busy_i=1 from N+1.
REQ-021 CTRL bit i=1 with unit i busy: no start pulse, err_i set sticky.
REQ-022 complete_i with busy_i=1: busy_i cleared, done_i set sticky, next cycle.
REQ-023 complete_i with busy_i=0: ignored, err_i set.
REQ-024 complete_i and CTRL bit i same cycle, busy_i=1: done_i set, start_i pulsed, busy_i stays 1, no err.
REQ-025 Multiple CTRL bits in one write: each unit handled independently, same cycle.
REQ-026 CLR clear and hardware set of same done/err bit same cycle: set wins.
REQ-027 PERF 32-bit, saturates at 0xFFFFFFFF; clear-write wins over increment.

Reset
REQ-028 rst high: busy, done, err, PERF, CFG0..7, regif_rdata, regif_rvalid, all start_* = 0 at next edge.
REQ-029 Reset mid-operation drops busy without a start/complete pulse; completes arriving on the cycle rst is high are discarded.

Structure
REQ-030 Package regif_pkg: address constants, unit index constants, VERSION value, N_UNIT.
REQ-031 Sub-module regif_unit_track: per-unit busy/done/err FSM (IDLE, BUSY), instantiated N_UNIT times.

Verification
REQ-032 Write 0x000=0x4 -> start_comp_conv one-cycle pulse at N+1; STATUS read = 0x00000004.
REQ-033 Pulse complete_comp_conv, read STATUS -> 0x00000400; write 0x002=0x400, read STATUS -> 0x0.
REQ-034 Write 0x000=0x1 twice while busy -> one start pulse; STATUS bit16=1.
REQ-035 Write 0x013=0xA5A5A5A5 with same-cycle ren of 0x013 -> rdata=0x0; next read -> 0xA5A5A5A5; cfg_reg[127:96]=0xA5A5A5A5.
REQ-036 Read 0x3FFFFF -> rdata=0xDEADBEEF, rvalid one cycle; read 0x003 -> 0x2CDA0001.
REQ-037 Start lpe, hold busy 10 cycles, assert rst -> STATUS=0, PERF=0, no start pulse after reset.

Source files
------------

// File: rtl/regif_pkg.sv
// Shared constants for the register-interface controller: register map,
// subunit indices, STATUS field layout and fixed read values.
package regif_pkg;

   localparam int unsigned N_UNIT = 7;
   localparam int unsigned N_CFG  = 8;

   // Register word addresses
   localparam int unsigned ADDR_CTRL    = 32'h000;
   localparam int unsigned ADDR_STATUS  = 32'h001;
   localparam int unsigned ADDR_CLR     = 32'h002;
   localparam int unsigned ADDR_VERSION = 32'h003;
   localparam int unsigned ADDR_PERF    = 32'h004;
   localparam int unsigned ADDR_CFG0    = 32'h010;

   // Subunit indices (bit position in CTRL and in each STATUS field)
   localparam int unsigned UNIT_MOV_DDR2GB    = 0;
   localparam int unsigned UNIT_MOV_GB2LB     = 1;
   localparam int unsigned UNIT_COMP_CONV     = 2;
   localparam int unsigned UNIT_COMP_FC       = 3;
   localparam int unsigned UNIT_COMP_APE      = 4;
   localparam int unsigned UNIT_COMP_RESHAPE  = 5;
   localparam int unsigned UNIT_LPE           = 6;

   // STATUS / CLR field offsets
   localparam int unsigned STAT_BUSY_LSB = 0;
   localparam int unsigned STAT_DONE_LSB = 8;
   localparam int unsigned STAT_ERR_LSB  = 16;

   localparam logic [31:0] VERSION_VAL    = 32'h2CDA_0001;
   localparam logic [31:0] RDATA_UNMAPPED = 32'hDEAD_BEEF;

   // Saturating 32-bit increment for the performance counter
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/regif_ctrl_if.sv
// Register bus bundle: word address, write/read strobes, write data and
// registered read data with its one-cycle valid pulse.
interface regif_ctrl_if #(
   parameter int unsigned ADDR_W = 22,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0] regif_addr;
   logic [DATA_W-1:0] regif_wdata;
   logic              regif_wen;
   logic              regif_ren;
   logic [DATA_W-1:0] regif_rdata;
   logic              regif_rvalid;

   modport master (
      output regif_addr, regif_wdata, regif_wen, regif_ren,
      input  regif_rdata, regif_rvalid
   );

   modport slave (
      input  regif_addr, regif_wdata, regif_wen, regif_ren,
      output regif_rdata, regif_rvalid
   );
endinterface

// File: rtl/regif_unit_track.sv
// Per-subunit tracker: busy state, sticky done/err flags and start pulse.
module regif_unit_track (
   input  logic clk,
   input  logic rst,
   input  logic start_req_i,
   input  logic complete_i,
   input  logic clr_done_i,
   input  logic clr_err_i,
   output logic start_o,
   output logic busy_o,
   output logic done_o,
   output logic err_o
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   logic [0:0] state_q, state_d;
   logic       start_q, start_d;
   logic       done_q, done_d;
   logic       err_q, err_d;
   logic       set_done, set_err;

   // Next state: a completion and a restart in the same cycle hand over
   // directly, keeping the unit busy; a hardware set beats a W1C clear.
   always_comb begin
      state_d  = state_q;
      start_d  = 1'b0;
      set_done = 1'b0;
      set_err  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_req_i) begin
               start_d = 1'b1;
               state_d = ST_BUSY;
            end
            if (complete_i) set_err = 1'b1;
         end
         ST_BUSY: begin
            if (complete_i) begin
               set_done = 1'b1;
               if (start_req_i) start_d = 1'b1;
               else             state_d = ST_IDLE;
            end else if (start_req_i) begin
               set_err = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      done_d = (done_q & ~clr_done_i) | set_done;
      err_d  = (err_q  & ~clr_err_i)  | set_err;
   end

   // State and flag registers; reset discards any in-flight completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign start_o = start_q;
   assign busy_o  = (state_q == ST_BUSY);
   assign done_o  = done_q;
   assign err_o   = err_q;

endmodule

// File: rtl/regif_ctrl.sv
// Register-interface controller: decodes bus accesses, launches subunits,
// tracks their status, counts busy cycles and holds eight config words.
module regif_ctrl #(
   parameter int unsigned ADDR_W = 22,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned N_UNIT = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   regif_ctrl_if.slave           bus,
   output logic                  start_mov_ddr2gb,
   output logic                  start_mov_gb2lb,
   output logic                  start_comp_conv,
   output logic                  start_comp_fc,
   output logic                  start_comp_ape,
   output logic                  start_comp_reshape,
   output logic                  start_lpe,
   input  logic                  complete_mov_ddr2gb,
   input  logic                  complete_mov_gb2lb,
   input  logic                  complete_comp_conv,
   input  logic                  complete_comp_fc,
   input  logic                  complete_comp_ape,
   input  logic                  complete_comp_reshape,
   input  logic                  complete_lpe,
   output logic [8*DATA_W-1:0]   cfg_reg
);
   import regif_pkg::*;

   logic [N_UNIT-1:0] unit_start, unit_busy, unit_done, unit_err, unit_cmpl;
   logic [N_UNIT-1:0] ctrl_req, clr_done, clr_err;

   logic              wr_ctrl, wr_clr, wr_perf, wr_cfg, cfg_hit;
   logic [2:0]        cfg_idx;
   logic [31:0]       perf_q, perf_d;
   logic [DATA_W-1:0] cfg_q [N_CFG];
   logic [DATA_W-1:0] status, rd_val;
   logic [DATA_W-1:0] rdata_q;
   logic              rvalid_q;

   assign cfg_hit = (bus.regif_addr[ADDR_W-1:3] == (ADDR_W-3)'(ADDR_CFG0 >> 3));
   assign cfg_idx = bus.regif_addr[2:0];
   assign wr_ctrl = bus.regif_wen && (bus.regif_addr == ADDR_W'(ADDR_CTRL));
   assign wr_clr  = bus.regif_wen && (bus.regif_addr == ADDR_W'(ADDR_CLR));
   assign wr_perf = bus.regif_wen && (bus.regif_addr == ADDR_W'(ADDR_PERF));
   assign wr_cfg  = bus.regif_wen && cfg_hit;

   // Per-unit request and clear strobes from CTRL / CLR writes.
   always_comb begin
      ctrl_req = wr_ctrl ? bus.regif_wdata[N_UNIT-1:0]             : '0;
      clr_done = wr_clr  ? bus.regif_wdata[STAT_DONE_LSB +: N_UNIT] : '0;
      clr_err  = wr_clr  ? bus.regif_wdata[STAT_ERR_LSB  +: N_UNIT] : '0;
   end

   // Gather named completion inputs into the unit-indexed vector.
   always_comb begin
      unit_cmpl = '0;
      unit_cmpl[UNIT_MOV_DDR2GB]   = complete_mov_ddr2gb;
      unit_cmpl[UNIT_MOV_GB2LB]    = complete_mov_gb2lb;
      unit_cmpl[UNIT_COMP_CONV]    = complete_comp_conv;
      unit_cmpl[UNIT_COMP_FC]      = complete_comp_fc;
      unit_cmpl[UNIT_COMP_APE]     = complete_comp_ape;
      unit_cmpl[UNIT_COMP_RESHAPE] = complete_comp_reshape;
      unit_cmpl[UNIT_LPE]          = complete_lpe;
   end

   for (genvar g = 0; g < N_UNIT; g++) begin : g_unit
      regif_unit_track u_track (
         .clk         (clk),
         .rst         (rst),
         .start_req_i (ctrl_req[g]),
         .complete_i  (unit_cmpl[g]),
         .clr_done_i  (clr_done[g]),
         .clr_err_i   (clr_err[g]),
         .start_o     (unit_start[g]),
         .busy_o      (unit_busy[g]),
         .done_o      (unit_done[g]),
         .err_o       (unit_err[g])
      );
   end

   assign start_mov_ddr2gb   = unit_start[UNIT_MOV_DDR2GB];
   assign start_mov_gb2lb    = unit_start[UNIT_MOV_GB2LB];
   assign start_comp_conv    = unit_start[UNIT_COMP_CONV];
   assign start_comp_fc      = unit_start[UNIT_COMP_FC];
   assign start_comp_ape     = unit_start[UNIT_COMP_APE];
   assign start_comp_reshape = unit_start[UNIT_COMP_RESHAPE];
   assign start_lpe          = unit_start[UNIT_LPE];

   // Busy-cycle counter: a clearing write takes priority over counting.
   always_comb begin
      perf_d = perf_q;
      if (wr_perf)         perf_d = '0;
      else if (|unit_busy) perf_d = sat_inc(perf_q);
   end

   // Performance counter register.
   always_ff @(posedge clk) begin
      if (rst) perf_q <= '0;
      else     perf_q <= perf_d;
   end

   // Configuration word storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < N_CFG; i++) cfg_q[i] <= '0;
      end else if (wr_cfg) begin
         cfg_q[cfg_idx] <= bus.regif_wdata;
      end
   end

   // Flatten configuration words, CFG0 in the LSBs.
   always_comb begin
      cfg_reg = '0;
      for (int unsigned i = 0; i < N_CFG; i++) cfg_reg[i*DATA_W +: DATA_W] = cfg_q[i];
   end

   // Read mux over current register contents (pre-write on same-cycle access).
   always_comb begin
      status = '0;
      status[STAT_BUSY_LSB +: N_UNIT] = unit_busy;
      status[STAT_DONE_LSB +: N_UNIT] = unit_done;
      status[STAT_ERR_LSB  +: N_UNIT] = unit_err;
      rd_val = DATA_W'(RDATA_UNMAPPED);
      if (cfg_hit)                                           rd_val = cfg_q[cfg_idx];
      else if (bus.regif_addr == ADDR_W'(ADDR_CTRL))         rd_val = '0;
      else if (bus.regif_addr == ADDR_W'(ADDR_STATUS))       rd_val = status;
      else if (bus.regif_addr == ADDR_W'(ADDR_CLR))          rd_val = '0;
      else if (bus.regif_addr == ADDR_W'(ADDR_VERSION))      rd_val = DATA_W'(VERSION_VAL);
      else if (bus.regif_addr == ADDR_W'(ADDR_PERF))         rd_val = DATA_W'(perf_q);
   end

   // Registered read response; data holds between reads.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= bus.regif_ren;
         if (bus.regif_ren) rdata_q <= rd_val;
      end
   end

   assign bus.regif_rdata  = rdata_q;
   assign bus.regif_rvalid = rvalid_q;

endmodule

// File: tb/tb_regif_ctrl.sv
// Self-checking bench for regif_ctrl: directed scenarios followed by random
// bus/completion traffic, all checked against a cycle-level register model.
module tb_regif_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  comp = '0;
   logic [6:0]  start_vec;
   logic [255:0] cfg_reg;
   logic        s0, s1, s2, s3, s4, s5, s6;

   regif_ctrl_if #(.ADDR_W(22), .DATA_W(32)) bus ();

   regif_ctrl #(.ADDR_W(22), .DATA_W(32), .N_UNIT(7)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .bus                   (bus),
      .start_mov_ddr2gb      (s0),
      .start_mov_gb2lb       (s1),
      .start_comp_conv       (s2),
      .start_comp_fc         (s3),
      .start_comp_ape        (s4),
      .start_comp_reshape    (s5),
      .start_lpe             (s6),
      .complete_mov_ddr2gb   (comp[0]),
      .complete_mov_gb2lb    (comp[1]),
      .complete_comp_conv    (comp[2]),
      .complete_comp_fc      (comp[3]),
      .complete_comp_ape     (comp[4]),
      .complete_comp_reshape (comp[5]),
      .complete_lpe          (comp[6]),
      .cfg_reg               (cfg_reg)
   );

   assign start_vec = {s6, s5, s4, s3, s2, s1, s0};

   always #5 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Reference model state
   logic [6:0]  m_busy = '0, m_done = '0, m_err = '0, m_start = '0;
   logic [31:0] m_perf = '0, m_rdata = '0;
   logic        m_rvalid = 1'b0;
   logic [31:0] m_cfg [8];

   task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [21:0] a);
      if (a == 22'h0 || a == 22'h2) return 32'h0;
      if (a == 22'h1) return {9'b0, m_err, 1'b0, m_done, 1'b0, m_busy};
      if (a == 22'h3) return 32'h2CDA0001;
      if (a == 22'h4) return m_perf;
      if (a >= 22'h10 && a <= 22'h17) return m_cfg[a - 22'h10];
      return 32'hDEADBEEF;
   endfunction

   // Apply the register rules for the inputs present at this edge.
   task automatic model_edge();
      logic [6:0]  req, cd, ce;
      logic [31:0] nperf;
      if (rst) begin
         m_busy = '0; m_done = '0; m_err = '0; m_start = '0;
         m_perf = '0; m_rdata = '0; m_rvalid = 1'b0;
         for (int i = 0; i < 8; i++) m_cfg[i] = '0;
         return;
      end
      m_rvalid = bus.regif_ren;
      if (bus.regif_ren) m_rdata = m_read(bus.regif_addr);
      req = (bus.regif_wen && bus.regif_addr == 22'h0) ? bus.regif_wdata[6:0] : 7'h0;
      cd  = (bus.regif_wen && bus.regif_addr == 22'h2) ? bus.regif_wdata[14:8] : 7'h0;
      ce  = (bus.regif_wen && bus.regif_addr == 22'h2) ? bus.regif_wdata[22:16] : 7'h0;
      if (bus.regif_wen && bus.regif_addr == 22'h4) nperf = 0;
      else if (m_busy != 0) nperf = (m_perf == 32'hFFFFFFFF) ? m_perf : m_perf + 1;
      else nperf = m_perf;
      m_perf = nperf;
      for (int i = 0; i < 7; i++) begin
         logic b, c, q;
         b = m_busy[i]; c = comp[i]; q = req[i];
         m_start[i] = q && (!b || c);
         m_busy[i]  = m_start[i] || (b && !c);
         m_done[i]  = (m_done[i] && !cd[i]) || (b && c);
         m_err[i]   = (m_err[i] && !ce[i]) || (q && b && !c) || (c && !b);
      end
      if (bus.regif_wen && bus.regif_addr >= 22'h10 && bus.regif_addr <= 22'h17)
         m_cfg[bus.regif_addr - 22'h10] = bus.regif_wdata;
   endtask

   task automatic step();
      logic [255:0] exp_cfg;
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < 8; i++) exp_cfg[i*32 +: 32] = m_cfg[i];
      check_eq("start", {249'b0, start_vec}, {249'b0, m_start});
      check_eq("rvalid", {255'b0, bus.regif_rvalid}, {255'b0, m_rvalid});
      check_eq("rdata", {224'b0, bus.regif_rdata}, {224'b0, m_rdata});
      check_eq("cfg_reg", cfg_reg, exp_cfg);
   endtask

   task automatic op(input logic w, input logic r, input logic [21:0] a,
                     input logic [31:0] d, input logic [6:0] c);
      bus.regif_wen = w; bus.regif_ren = r; bus.regif_addr = a;
      bus.regif_wdata = d; comp = c;
      step();
      bus.regif_wen = 1'b0; bus.regif_ren = 1'b0; comp = '0;
   endtask

   function automatic logic [21:0] rand_addr();
      int unsigned k;
      k = $urandom_range(0, 15);
      if (k < 5)  return 22'(k);
      if (k < 13) return 22'h10 + 22'(k - 5);
      return 22'($urandom);
   endfunction

   initial begin
      for (int i = 0; i < 8; i++) m_cfg[i] = '0;
      bus.regif_wen = 1'b0; bus.regif_ren = 1'b0;
      bus.regif_addr = '0; bus.regif_wdata = '0;

      // Reset state
      step(); step();
      rst = 1'b0;
      op(0, 1, 22'h1, 0, 0);
      check_eq("rst_status", {224'b0, bus.regif_rdata}, 256'h0);
      op(0, 1, 22'h4, 0, 0);
      check_eq("rst_perf", {224'b0, bus.regif_rdata}, 256'h0);

      // Start comp_conv
      op(1, 0, 22'h0, 32'h4, 0);
      check_eq("conv_start", {249'b0, start_vec}, 256'h4);
      op(0, 0, 0, 0, 0);
      check_eq("conv_pulse_end", {249'b0, start_vec}, 256'h0);
      op(0, 1, 22'h1, 0, 0);
      check_eq("conv_busy", {224'b0, bus.regif_rdata}, 256'h4);

      // Complete then W1C clear
      op(0, 0, 0, 0, 7'h04);
      op(0, 1, 22'h1, 0, 0);
      check_eq("conv_done", {224'b0, bus.regif_rdata}, 256'h400);
      op(1, 0, 22'h2, 32'h400, 0);
      op(0, 1, 22'h1, 0, 0);
      check_eq("conv_clr", {224'b0, bus.regif_rdata}, 256'h0);

      // Double start while busy
      op(1, 0, 22'h0, 32'h1, 0);
      check_eq("dbl_start1", {249'b0, start_vec}, 256'h1);
      op(1, 0, 22'h0, 32'h1, 0);
      check_eq("dbl_start2", {249'b0, start_vec}, 256'h0);
      op(0, 1, 22'h1, 0, 0);
      check_eq("dbl_err", {224'b0, bus.regif_rdata}, 256'h10001);
      op(0, 0, 0, 0, 7'h01);
      op(1, 0, 22'h2, 32'h00010100, 0);

      // Completion and restart on the same cycle
      op(1, 0, 22'h0, 32'h2, 0);
      op(1, 0, 22'h0, 32'h2, 7'h02);
      check_eq("handover_start", {249'b0, start_vec}, 256'h2);
      op(0, 1, 22'h1, 0, 0);
      check_eq("handover_status", {224'b0, bus.regif_rdata}, 256'h202);
      op(0, 0, 0, 0, 7'h02);
      op(1, 0, 22'h2, 32'h00FFFF00, 0);

      // Same-cycle write and read of CFG3
      op(1, 1, 22'h13, 32'hA5A5A5A5, 0);
      check_eq("cfg3_prewrite", {224'b0, bus.regif_rdata}, 256'h0);
      op(0, 1, 22'h13, 0, 0);
      check_eq("cfg3_read", {224'b0, bus.regif_rdata}, 256'hA5A5A5A5);
      check_eq("cfg3_port", {224'b0, cfg_reg[127:96]}, 256'hA5A5A5A5);

      // Unmapped read and VERSION
      op(0, 1, 22'h3FFFFF, 0, 0);
      check_eq("unmapped", {224'b0, bus.regif_rdata}, 256'hDEADBEEF);
      check_eq("unmapped_rv", {255'b0, bus.regif_rvalid}, 256'h1);
      op(0, 0, 0, 0, 0);
      check_eq("rvalid_drop", {255'b0, bus.regif_rvalid}, 256'h0);
      op(0, 1, 22'h3, 0, 0);
      check_eq("version", {224'b0, bus.regif_rdata}, 256'h2CDA0001);

      // lpe busy, PERF counting, reset mid-operation
      op(1, 0, 22'h4, 0, 0);
      op(1, 0, 22'h0, 32'h40, 0);
      check_eq("lpe_start", {249'b0, start_vec}, 256'h40);
      repeat (10) op(0, 0, 0, 0, 0);
      op(0, 1, 22'h4, 0, 0);
      check_eq("perf_count", {224'b0, bus.regif_rdata}, 256'd10);
      rst = 1'b1;
      op(0, 0, 0, 0, 7'h40);
      rst = 1'b0;
      check_eq("rst_nostart", {249'b0, start_vec}, 256'h0);
      op(0, 1, 22'h1, 0, 0);
      check_eq("rst_status2", {224'b0, bus.regif_rdata}, 256'h0);
      op(0, 1, 22'h4, 0, 0);
      check_eq("rst_perf2", {224'b0, bus.regif_rdata}, 256'h0);
      op(0, 0, 0, 0, 0);
      check_eq("rst_nostart2", {249'b0, start_vec}, 256'h0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         logic [21:0] a;
         logic [31:0] d;
         logic [6:0]  c;
         a = rand_addr();
         d = $urandom;
         if (a == 22'h0) d = $urandom & $urandom & 32'h7F;
         for (int i = 0; i < 7; i++) c[i] = ($urandom_range(0, 5) == 0);
         rst = ($urandom_range(0, 299) == 0);
         op(($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1, a, d, c);
         rst = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
